// File: rtl/umi_switch_pkg.sv
// Shared definitions for the UMI N x M crossbar switch.
// Arbitration mode encodings used by the top level and the per-output arbiter.
package umi_switch_pkg;

    localparam logic [1:0] ARB_PRIORITY = 2'b00;
    localparam logic [1:0] ARB_RR       = 2'b01;

endpackage

// File: rtl/umi_switch_arbiter.sv
// Per-output arbiter for the UMI crossbar: fixed priority or round-robin,
// with the grant locked while the output is stalled by backpressure.
module umi_switch_arbiter
    import umi_switch_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   mode_i,
    input  logic [N-1:0] req_i,
    input  logic         ready_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic [N-1:0]  held_q, held_d;
    logic [N-1:0]  upper;
    logic [N-1:0]  fresh;
    logic [PW-1:0] widx;
    logic          valid;
    logic          xfer;

    function automatic logic [N-1:0] first_one(input logic [N-1:0] v);
        logic [N-1:0] g;
        g = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    // Round-robin: prefer requesters at or above the pointer, else wrap.
    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = req_i[i] & (PW'(i) >= ptr_q);
        end
        if (mode_i == ARB_PRIORITY) begin
            fresh = first_one(req_i);
        end else if (|upper) begin
            fresh = first_one(upper);
        end else begin
            fresh = first_one(req_i);
        end
    end

    assign valid   = |req_i;
    assign xfer    = valid & ready_i;
    assign grant_o = (lock_q && |(held_q & req_i)) ? held_q : fresh;

    always_comb begin
        widx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_o[i]) begin
                widx = PW'(i);
            end
        end
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (widx == PW'(N - 1)) ? '0 : widx + 1'b1;
        end
        lock_d = valid & ~ready_i;
        held_d = grant_o;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            lock_q <= 1'b0;
            held_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
            held_q <= held_d;
        end
    end

endmodule

// File: rtl/umi_switch_nxm.sv
// Zero-latency N-input, M-output UMI crossbar.
// Masks requests, arbitrates each output and AND-OR muxes the payload.
module umi_switch_nxm
    import umi_switch_pkg::*;
#(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int DW   = 256,
    parameter int AW   = 64,
    parameter int CW   = 32,
    parameter int MASK = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      arbmode,
    input  logic [N*M-1:0]  arbmask,
    input  logic [N*M-1:0]  umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic [M-1:0]    umi_out_valid,
    output logic [M*CW-1:0] umi_out_cmd,
    output logic [M*AW-1:0] umi_out_dstaddr,
    output logic [M*AW-1:0] umi_out_srcaddr,
    output logic [M*DW-1:0] umi_out_data,
    input  logic [M-1:0]    umi_out_ready
);

    localparam logic MASK_EN = (MASK != 0);

    logic [N-1:0] gnt [M];

    for (genvar j = 0; j < M; j++) begin : g_out
        logic [N-1:0]  req;
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;

        assign req = umi_in_valid[j*N +: N]
                   & ~({N{MASK_EN}} & arbmask[j*N +: N]);

        umi_switch_arbiter #(
            .N (N)
        ) u_arb (
            .clk     (clk),
            .reset   (reset),
            .mode_i  (arbmode),
            .req_i   (req),
            .ready_i (umi_out_ready[j]),
            .grant_o (gnt[j])
        );

        // One-hot grant makes the AND-OR mux zero when nothing is granted.
        always_comb begin
            cmd  = '0;
            dst  = '0;
            src  = '0;
            data = '0;
            for (int i = 0; i < N; i++) begin
                cmd  = cmd  | ({CW{gnt[j][i]}} & umi_in_cmd[i*CW +: CW]);
                dst  = dst  | ({AW{gnt[j][i]}} & umi_in_dstaddr[i*AW +: AW]);
                src  = src  | ({AW{gnt[j][i]}} & umi_in_srcaddr[i*AW +: AW]);
                data = data | ({DW{gnt[j][i]}} & umi_in_data[i*DW +: DW]);
            end
        end

        assign umi_out_valid[j]            = |req;
        assign umi_out_cmd[j*CW +: CW]     = cmd;
        assign umi_out_dstaddr[j*AW +: AW] = dst;
        assign umi_out_srcaddr[j*AW +: AW] = src;
        assign umi_out_data[j*DW +: DW]    = data;
    end

    always_comb begin
        umi_in_ready = '0;
        for (int j = 0; j < M; j++) begin
            for (int i = 0; i < N; i++) begin
                umi_in_ready[i] = umi_in_ready[i]
                                | (gnt[j][i] & umi_out_ready[j]);
            end
        end
    end

endmodule

// File: tb/tb_umi_switch_nxm.sv
// Directed scoreboard bench for the UMI N x M crossbar.
// Each input carries a fixed payload so the winner of each output is visible.
module tb_umi_switch_nxm;

    localparam int N  = 4;
    localparam int M  = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      arbmode;
    logic [N*M-1:0]  arbmask;
    logic [N*M-1:0]  umi_in_valid;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dstaddr;
    logic [N*AW-1:0] umi_in_srcaddr;
    logic [N*DW-1:0] umi_in_data;
    logic [N-1:0]    umi_in_ready;
    logic [M-1:0]    umi_out_valid;
    logic [M*CW-1:0] umi_out_cmd;
    logic [M*AW-1:0] umi_out_dstaddr;
    logic [M*AW-1:0] umi_out_srcaddr;
    logic [M*DW-1:0] umi_out_data;
    logic [M-1:0]    umi_out_ready;

    int checks   = 0;
    int failures = 0;

    string      tag_q [$];
    logic [3:0] ov_q  [$];
    logic [3:0] ir_q  [$];
    int         w_q   [$];

    always #5 clk = ~clk;

    umi_switch_nxm #(
        .N    (N),
        .M    (M),
        .DW   (DW),
        .AW   (AW),
        .CW   (CW),
        .MASK (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .arbmode         (arbmode),
        .arbmask         (arbmask),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready)
    );

    function automatic logic [63:0] edata(input int w);
        return (w < 0) ? 64'h0 : 64'(32'hA3 + w);
    endfunction

    function automatic logic [63:0] ecmd(input int w);
        return (w < 0) ? 64'h0 : 64'(8'h30 + w);
    endfunction

    function automatic logic [63:0] esrc(input int w);
        return (w < 0) ? 64'h0 : 64'(16'h2000 + w);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push expectations, compare at the falling edge, advance one cycle.
    task automatic step(input string tag, input logic [3:0] ov,
                        input logic [3:0] ir, input int w0, input int w1,
                        input int w2, input int w3);
        string      t;
        logic [3:0] eov;
        logic [3:0] eir;
        int         w [4];
        tag_q.push_back(tag);
        ov_q.push_back(ov);
        ir_q.push_back(ir);
        w_q.push_back(w0);
        w_q.push_back(w1);
        w_q.push_back(w2);
        w_q.push_back(w3);
        @(negedge clk);
        if (tag_q.size() == 0 || w_q.size() < 4) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            t   = tag_q.pop_front();
            eov = ov_q.pop_front();
            eir = ir_q.pop_front();
            for (int j = 0; j < 4; j++) w[j] = w_q.pop_front();
            chk({t, ".out_valid"}, 64'(umi_out_valid), 64'(eov));
            chk({t, ".in_ready"}, 64'(umi_in_ready), 64'(eir));
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("%s.data%0d", t, j),
                    64'(umi_out_data[j*DW +: DW]), edata(w[j]));
                chk($sformatf("%s.cmd%0d", t, j),
                    64'(umi_out_cmd[j*CW +: CW]), ecmd(w[j]));
                chk($sformatf("%s.src%0d", t, j),
                    64'(umi_out_srcaddr[j*AW +: AW]), esrc(w[j]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            umi_in_cmd[i*CW +: CW]     = 8'(8'h30 + i);
            umi_in_dstaddr[i*AW +: AW] = 16'(16'h1000 + i);
            umi_in_srcaddr[i*AW +: AW] = 16'(16'h2000 + i);
            umi_in_data[i*DW +: DW]    = 32'(32'hA3 + i);
        end
        reset         = 1'b1;
        arbmode       = 2'b00;
        arbmask       = '0;
        umi_in_valid  = '0;
        umi_out_ready = 4'hF;
        @(posedge clk);
        #1;
        step("rst0", 4'h0, 4'h0, -1, -1, -1, -1);
        step("rst1", 4'h0, 4'h0, -1, -1, -1, -1);
        reset = 1'b0;

        // Input 2 to output 1
        umi_in_valid = 16'h0040;
        step("single", 4'b0010, 4'b0100, -1, 2, -1, -1);

        // Fixed priority on output 0: inputs 0 and 3
        umi_in_valid = 16'h0009;
        step("fp0", 4'b0001, 4'b0001, 0, -1, -1, -1);
        step("fp1", 4'b0001, 4'b0001, 0, -1, -1, -1);
        step("fp2", 4'b0001, 4'b0001, 0, -1, -1, -1);
        umi_in_valid = 16'h0008;
        step("fp3", 4'b0001, 4'b1000, 3, -1, -1, -1);

        // Round-robin on output 2: all inputs
        arbmode      = 2'b01;
        umi_in_valid = 16'h0F00;
        step("rr0", 4'b0100, 4'b0001, -1, -1, 0, -1);
        step("rr1", 4'b0100, 4'b0010, -1, -1, 1, -1);
        step("rr2", 4'b0100, 4'b0100, -1, -1, 2, -1);
        step("rr3", 4'b0100, 4'b1000, -1, -1, 3, -1);
        step("rr4", 4'b0100, 4'b0001, -1, -1, 0, -1);

        // Backpressure on output 3; input 0 joins mid-stall
        umi_in_valid  = 16'h6000;
        umi_out_ready = 4'b0111;
        step("bp0", 4'b1000, 4'b0000, -1, -1, -1, 1);
        umi_in_valid = 16'h7000;
        step("bp1", 4'b1000, 4'b0000, -1, -1, -1, 1);
        step("bp2", 4'b1000, 4'b0000, -1, -1, -1, 1);
        step("bp3", 4'b1000, 4'b0000, -1, -1, -1, 1);
        step("bp4", 4'b1000, 4'b0000, -1, -1, -1, 1);
        umi_out_ready = 4'hF;
        step("bp_xfer", 4'b1000, 4'b0010, -1, -1, -1, 1);
        step("bp_next", 4'b1000, 4'b0100, -1, -1, -1, 2);
        umi_in_valid = '0;
        step("idle0", 4'b0000, 4'b0000, -1, -1, -1, -1);

        // Parallel: inputs 0..3 to outputs 3..0
        umi_in_valid = 16'h1248;
        step("par", 4'hF, 4'hF, 3, 2, 1, 0);

        // Mask blocks input 0 from output 0
        arbmask      = 16'h0001;
        umi_in_valid = 16'h0001;
        step("mask", 4'b0000, 4'b0000, -1, -1, -1, -1);

        // Reset during a stall drops the lock and the pointer
        arbmask       = '0;
        umi_in_valid  = 16'h6000;
        umi_out_ready = 4'b0111;
        step("stall", 4'b1000, 4'b0000, -1, -1, -1, 1);
        reset = 1'b1;
        step("rst_stall", 4'b1000, 4'b0000, -1, -1, -1, 1);
        reset        = 1'b0;
        umi_in_valid = 16'h7000;
        step("post_rst", 4'b1000, 4'b0000, -1, -1, -1, 0);
        umi_out_ready = 4'hF;
        step("post_xfer", 4'b1000, 4'b0001, -1, -1, -1, 0);
        umi_in_valid = '0;
        step("idle1", 4'b0000, 4'b0000, -1, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/umi_switch_nxm.md
# umi_switch_nxm

N-input, M-output combinational UMI crossbar with a per-output arbiter. Each input presents one transaction plus a one-hot per-output request vector (decoded externally from dstaddr). Each output selects one requesting input and forwards its cmd/dstaddr/srcaddr/data. The block sits between UMI hosts and devices in a fabric and adds zero cycles of latency.

## Interface
- N, default 4: number of inputs.
- M, default 4: number of outputs.
- DW, default 256: data width. AW, default 64: address width. CW, default 32: command width.
- MASK, default 0: 1 = arbmask is honoured; 0 = arbmask is ignored.
- clk  in  1  clock. One clock only.
- reset  in  1  reset, synchronous, active-high.
- arbmode  in  2  00 = fixed priority, 01 = round-robin, 10/11 = round-robin.
- arbmask  in  N*M  bit j*N+i set blocks input i from output j (when MASK=1).
- umi_in_valid  in  N*M  bit j*N+i: input i requests output j.
- umi_in_cmd/dstaddr/srcaddr/data  in  N*CW / N*AW / N*AW / N*DW  per-input fields, slice i.
- umi_in_ready  out  N  per-input ready.
- umi_out_valid  out  M.
- umi_out_cmd/dstaddr/srcaddr/data  out  M*CW / M*AW / M*AW / M*DW  slice j.
- umi_out_ready  in  M.

## Operation
- req[j][i] = umi_in_valid[j*N+i] & ~(MASK & arbmask[j*N+i]).
- Each input asserts at most one request bit at a time. Multiple bits set by one input is illegal, and the result is undefined.
- Per output j, the arbiter produces a one-hot grant[j] over the N inputs:
  - Fixed priority: the lowest input index wins.
  - Round-robin: search starts at ptr[j]. ptr[j] moves to (winner+1) mod N after each accepted transfer (out_valid & out_ready).
- Lock: while umi_out_valid[j] & ~umi_out_ready[j], grant[j] is held to the previous cycle's winner. This keeps the output payload stable per UMI rules. The lock clears on transfer.
- umi_out_valid[j] = |req[j].
- Output fields = AND-OR mux of the input slices by grant[j]. Fields are 0 when there is no grant.
- umi_in_ready[i] = OR over j of (grant[j][i] & umi_out_ready[j]). It is 0 when input i has no grant.
- Only payload bits pass through. Transactions are never split or merged.

## Timing
- All valid, data and ready paths are purely combinational, with zero latency.
- State is ptr[j] (log2 N bits) and lock/held-grant per output. All state updates on the clk rising edge.
- Reset: ptr = 0 and locks cleared. Outputs follow inputs combinationally. With umi_in_valid = 0, umi_out_valid = 0 and umi_in_ready = 0.
- Reset asserted mid-stall clears the lock, so arbitration restarts fresh on the next cycle.
- Simultaneous requests: exactly one input is granted per output per cycle. Different outputs proceed independently in the same cycle.
- A change of arbmode takes effect on the next arbitration. It does not affect a locked output.

## Structure
- Shared package `umi_switch_pkg`: arbmode encodings (ARB_PRIORITY = 2'b00, ARB_RR = 2'b01).
- One sub-module `umi_switch_arbiter`, instantiated M times:
  - Inputs: N requests, mode, clk, reset, ready.
  - Outputs: one-hot grant.
  - Contains the round-robin pointer and lock.
- The top level handles request masking, the generate loop of M arbiters and muxes, and the ready OR-reduction.

## Test plan
- Single path: input 2 requests output 1 (bit 1*4+2), out_ready = 1, data = 0xA5. Expect umi_out_valid = 4'b0010 and out_data[1] = 0xA5 in the same cycle, umi_in_ready = 4'b0100.
- Fixed-priority contention: inputs 0 and 3 both request output 0, arbmode = 00. Input 0 is granted every cycle. Input 3 waits until input 0 drops valid.
- Round-robin: all 4 inputs request output 2 continuously, arbmode = 01. Grants rotate 0,1,2,3,0.
- Backpressure lock: inputs 1 and 2 request output 3, out_ready[3] = 0 for 5 cycles. Output payload and grant stay on the first winner, and in_ready = 0 throughout. Raising ready transfers exactly one beat.
- Parallel: inputs 0 to 3 target outputs 3,2,1,0. All four transfer in one cycle, and umi_in_ready = 4'hF.
- Mask: MASK = 1, arbmask bit 0 set, input 0 requests output 0. umi_out_valid[0] = 0 and umi_in_ready[0] = 0. Reset mid-stall, then check outputs recover with no stale grant.
